// File: rtl/seg_page_scheduler.sv
// Round-robin pager for a two-digit 7-segment display shared by N_SRC requesters.
// Supports urgent preemption, manual advance and a blank gap between pages. Outputs are registered and active-low.
module seg_page_scheduler #(
  parameter int N_SRC        = 4,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLANK_CYCLES = 5000000,
  parameter int CNT_W        = 26
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [8*N_SRC-1:0]   i_value,
  input  logic [N_SRC-1:0]     i_valid,
  input  logic [N_SRC-1:0]     i_urgent,
  input  logic                 i_next,
  output logic [15:0]          o_SEG,
  output logic [1:0]           o_page,
  output logic                 o_urgent
);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK, URGENT} state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [6:0]       DASH       = 7'b0111111;

  state_t           state, state_nxt;
  logic [1:0]       page, page_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      seg_nxt;
  logic [7:0]       cur_value;
  logic             cur_valid;
  pick_t            adv_pick, blk_pick, low_pick, urg_pick;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    logic [2:0] s;
    s = {1'b0, p} + 3'd1;
    if (s >= 3'(N_SRC)) s = 3'd0;
    return s[1:0];
  endfunction

  // Rotate the mask so that 'start' lands on bit 0, then take the lowest set bit.
  function automatic pick_t first_from(input logic [N_SRC-1:0] mask, input logic [1:0] start);
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    logic [1:0]         off;
    logic [2:0]         sum;
    pick_t              r;
    dbl     = {mask, mask};
    rot     = N_SRC'(dbl >> start);
    off     = 2'd0;
    r.found = 1'b0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (rot[j]) begin
        r.found = 1'b1;
        off     = 2'(j);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= 3'(N_SRC)) sum = sum - 3'(N_SRC);
    r.idx = sum[1:0];
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] page_word(input logic [7:0] v, input logic [1:0] p);
    logic [7:0] tens, units;
    tens  = v / 8'd10;
    units = v - tens * 8'd10;
    if (v > 8'd99) return {~p[1], DASH, ~p[0], DASH};
    return {~p[1], seg7(tens[3:0]), ~p[0], seg7(units[3:0])};
  endfunction

  assign cur_value = 8'(i_value >> {page, 3'b000});
  assign cur_valid = |(i_valid & (N_SRC'(1) << page));
  assign adv_pick  = first_from(i_valid, wrap_inc(page));
  assign blk_pick  = first_from(i_valid, page);
  assign low_pick  = first_from(i_valid, 2'd0);
  assign urg_pick  = first_from(i_urgent, 2'd0);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    cnt_nxt   = cnt;
    if (!i_enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (urg_pick.found) begin
      state_nxt = URGENT;
      page_nxt  = urg_pick.idx;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (low_pick.found) begin
            state_nxt = SHOW;
            page_nxt  = low_pick.idx;
          end
        end
        SHOW: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (!low_pick.found) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (!cur_valid) begin
            state_nxt = BLANK;
            page_nxt  = adv_pick.idx;
            cnt_nxt   = '0;
          end else if (cnt == HOLD_LAST || i_next) begin
            // A lone valid page restarts its hold without a blank gap.
            cnt_nxt = '0;
            if (adv_pick.idx != page) begin
              state_nxt = BLANK;
              page_nxt  = adv_pick.idx;
            end
          end
        end
        BLANK: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == BLANK_LAST) begin
            cnt_nxt   = '0;
            state_nxt = blk_pick.found ? SHOW : IDLE;
            if (blk_pick.found) page_nxt = blk_pick.idx;
          end
        end
        URGENT: begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (adv_pick.found) page_nxt = adv_pick.idx;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    seg_nxt = 16'hFFFF;
    if (i_enable) begin
      case (state)
        SHOW, URGENT: seg_nxt = page_word(cur_value, page);
        IDLE:         if (!low_pick.found) seg_nxt = 16'hBFBF;
        default:      seg_nxt = 16'hFFFF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      page     <= 2'd0;
      cnt      <= '0;
      o_SEG    <= 16'hFFFF;
      o_page   <= 2'd0;
      o_urgent <= 1'b0;
    end else begin
      state    <= state_nxt;
      page     <= page_nxt;
      cnt      <= cnt_nxt;
      o_SEG    <= seg_nxt;
      o_page   <= page;
      o_urgent <= (state == URGENT);
    end
  end

endmodule

// File: doc/seg_page_scheduler.md
Name: seg_page_scheduler

Overview:
- Time-shares the board's two-digit 7-segment display pair between N_SRC requesters, each publishing a 2-digit decimal value (0..99).
- Rotates round-robin through the enabled pages, with a fixed hold time per page and a blank gap between pages.
- An urgent request preempts the rotation, and a manual i_next pulse advances to the next page.
- Output is the registered 16-bit segment word for both digits, active-low, {dp1,g..a digit1, dp0,g..a digit0}; it drives the display pins directly.

Parameters:
- N_SRC, 4, number of requesters; range 2..4, because the page index is shown on the 2 decimal points.
- HOLD_CYCLES, 50000000, number of clock cycles a page stays in SHOW.
- BLANK_CYCLES, 5000000, number of clock cycles of the all-off gap between two different pages.
- CNT_W, 26, width of the hold/blank counter; must hold max(HOLD_CYCLES, BLANK_CYCLES).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  display enable; when low, the display is blank and the FSM is held in IDLE.
- i_value  in  8*N_SRC  source k value in bits [8k+7:8k], unsigned decimal.
- i_valid  in  N_SRC  page k is eligible for rotation.
- i_urgent  in  N_SRC  page k requests preemption.
- i_next  in  1  single-cycle pulse that advances the page early.
- o_SEG  out  16  segment word, 0 = segment ON.
- o_page  out  2  index of the page currently selected.
- o_urgent  out  1  high while in URGENT.

Behaviour:
- Reset (i_reset=1 at a rising edge): state=IDLE, counter=0, page=0; o_SEG=16'hFFFF, o_page=0, o_urgent=0. Reset mid-page aborts immediately.
- Digit encoding:
  - value v in 0..99: digit1=tens, digit0=units, standard 0-9 active-low patterns (e.g. 0=7'b1000000, 7=7'b1111000).
  - v>99: both digits show dash 7'b0111111.
- Decimal points in SHOW/URGENT: dp1=~page[1], dp0=~page[0] (active-low binary page index).
- IDLE and BLANK: all 16 bits = 1. Exception: in IDLE with i_enable=1 and no valid page, o_SEG=16'hBFBF (dashes, dp off).
- o_SEG and o_page are registered and reflect the state/selection of the previous cycle (1-cycle latency). The value is sampled live every cycle, not latched at page entry.
- FSM states: IDLE, SHOW, BLANK, URGENT. Priority per cycle: reset > !i_enable > urgent > others.
- Any state, i_enable=0: go to IDLE, counter=0.
- Any state, |i_urgent (enabled): go to URGENT with page = lowest index with i_urgent set, re-evaluated every cycle. No blank gap on entry or when switching between urgent sources.
- URGENT, no urgent bit set: go to BLANK, counter=0. The next page is the first valid index after the last urgent page, with wrap-around.
- IDLE, |i_valid: go to SHOW; page = lowest valid index; counter=0.
- SHOW:
  - counter increments each cycle.
  - Leave when counter==HOLD_CYCLES-1 or on i_next.
  - i_next coinciding with expiry produces one advance only.
  - Next page = next higher valid index, wrapping mod N_SRC.
  - If the next page equals the current page (only one valid), stay in SHOW with counter=0 and no blank.
  - Otherwise go to BLANK, counter=0.
  - If no page is valid, go to IDLE.
- SHOW, current i_valid bit drops: go to BLANK immediately, counter=0.
- BLANK: counter increments each cycle. At counter==BLANK_CYCLES-1, go to SHOW on the pending page, re-checked against i_valid. If the pending page is no longer valid, take the next valid page; if none, go to IDLE. i_next is ignored in BLANK, IDLE and URGENT.
- Pending-page computation is combinational over i_valid using a rotate-and-priority-encode; one pass, no loops over time.

Test Plan (HOLD_CYCLES=8, BLANK_CYCLES=2, N_SRC=4):
- Reset and rotation: reset, then i_enable=1, i_valid=4'b0101, values 8'd12 and 8'd47 on pages 0 and 2 → o_SEG=16'hFFFF during reset. Then page 0 shows "12" {dp1 off, dp0 off} for 8 cycles, 2 cycles 16'hFFFF, page 2 shows "47" with dp1 on, then back to page 0.
- Single valid page: i_valid=4'b0010, value 8'd99 → "99" shown continuously with no blank cycles; o_page=1 steady.
- Manual advance: i_next pulsed on cycle 3 of page 0 with i_valid=4'b1111 → BLANK starts the next cycle, page 1 follows. A pulse coinciding with cycle 8 gives a single advance to page 1, not 2.
- Urgent preemption: during page 1 blank, raise i_urgent=4'b1000 → URGENT next cycle, o_urgent=1, o_page=3, no blank. Add i_urgent bit 0 → switch to page 0. Drop all urgent bits → 2 blank cycles, then page 1.
- Out of range: page 0 value 8'd150 → o_SEG digits both 7'b0111111.
- Boundaries: i_valid=0 with enable → 16'hBFBF. Deassert page valid mid-SHOW → BLANK next cycle. i_enable=0 mid-page → 16'hFFFF and IDLE. Re-enable → restart at the lowest valid page.
